// File: rtl/peak_pkg.sv
// Shared defaults and FSM encoding for the peak averaging datapath.
package peak_pkg;

    localparam int PEAK_WFM_WIDTH  = 8;
    localparam int PEAK_DATA_WIDTH = 32;
    localparam int PEAK_LOG_N_MAX  = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } avg_state_t;

endpackage

// File: rtl/axis_hold_reg.sv
// Single-entry output register with valid/ready handshake and a sticky drop flag.
module axis_hold_reg #(
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             overflow
);

    logic accept;

    assign accept = m_valid & m_ready;

    // A new result may replace the held one only when the slot is free or
    // is being accepted this cycle; otherwise the new one is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
            overflow <= 1'b0;
        end else if (load_valid) begin
            if (!m_valid || accept) begin
                m_valid <= 1'b1;
                m_data  <= load_data;
            end else begin
                overflow <= 1'b1;
            end
        end else if (accept) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/peak_averager.sv
// Averages 2^n consecutive (peak value, peak address) pairs and emits one
// result per batch through a held AXI-stream style output.
module peak_averager
    import peak_pkg::*;
#(
    parameter int WFM_WIDTH  = PEAK_WFM_WIDTH,
    parameter int DATA_WIDTH = PEAK_DATA_WIDTH,
    parameter int LOG_N_MAX  = PEAK_LOG_N_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            log_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_max,
    input  logic [WFM_WIDTH-1:0]  s_axis_tdata_addr,
    input  logic                  s_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_max,
    output logic [WFM_WIDTH-1:0]  m_axis_tdata_addr,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  overflow
);

    localparam int CNT_W   = LOG_N_MAX + 1;
    localparam int SUM_V_W = DATA_WIDTH + LOG_N_MAX;
    localparam int SUM_A_W = WFM_WIDTH + LOG_N_MAX;

    avg_state_t           state, state_next;
    logic [CNT_W-1:0]     count, count_next, count_inc;
    logic [SUM_V_W-1:0]   sum_v, sum_v_next, sum_v_acc;
    logic [SUM_A_W-1:0]   sum_a, sum_a_next, sum_a_acc;
    logic [3:0]           n_lat, n_lat_next, n_eff, log_n_clamped;
    logic                 batch_close;
    logic [DATA_WIDTH-1:0] res_max;
    logic [WFM_WIDTH-1:0]  res_addr;

    assign log_n_clamped = (log_n > 4'(LOG_N_MAX)) ? 4'(LOG_N_MAX) : log_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            sum_v <= '0;
            sum_a <= '0;
            n_lat <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            sum_v <= sum_v_next;
            sum_a <= sum_a_next;
            n_lat <= n_lat_next;
        end
    end

    // The first sample of a batch uses the live (clamped) log_n so that an
    // n=0 batch closes on that very sample; later samples use the latched n.
    always_comb begin
        state_next  = state;
        count_next  = count;
        sum_v_next  = sum_v;
        sum_a_next  = sum_a;
        n_lat_next  = n_lat;
        batch_close = 1'b0;
        n_eff       = (state == IDLE) ? log_n_clamped : n_lat;
        count_inc   = count + 1'b1;
        sum_v_acc   = sum_v + SUM_V_W'(s_axis_tdata_max);
        sum_a_acc   = sum_a + SUM_A_W'(s_axis_tdata_addr);
        res_max     = DATA_WIDTH'(sum_v_acc >> n_eff);
        res_addr    = WFM_WIDTH'(sum_a_acc >> n_eff);

        if (s_axis_tvalid) begin
            batch_close = (count_inc == (CNT_W'(1) << n_eff));
            if (batch_close) begin
                state_next = IDLE;
                count_next = '0;
                sum_v_next = '0;
                sum_a_next = '0;
            end else begin
                state_next = ACCUM;
                count_next = count_inc;
                sum_v_next = sum_v_acc;
                sum_a_next = sum_a_acc;
                if (state == IDLE) begin
                    n_lat_next = log_n_clamped;
                end
            end
        end
    end

    axis_hold_reg #(
        .WIDTH(DATA_WIDTH + WFM_WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load_valid(s_axis_tvalid & batch_close),
        .load_data ({res_max, res_addr}),
        .m_ready   (m_axis_tready),
        .m_valid   (m_axis_tvalid),
        .m_data    ({m_axis_tdata_max, m_axis_tdata_addr}),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_peak_averager.sv
// Scoreboard bench for peak_averager: a batch model pushes expected results,
// a handshake monitor pops and compares them; directed checks cover timing.
module tb_peak_averager;

    logic        clk;
    logic        rst;
    logic [3:0]  log_n;
    logic [31:0] s_axis_tdata_max;
    logic [7:0]  s_axis_tdata_addr;
    logic        s_axis_tvalid;
    logic [31:0] m_axis_tdata_max;
    logic [7:0]  m_axis_tdata_addr;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        overflow;

    typedef struct packed {
        logic [31:0] mx;
        logic [7:0]  ad;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          m_count = 0;
    int          m_n = 0;
    logic [63:0] m_sum_v = '0;
    logic [63:0] m_sum_a = '0;

    peak_averager dut (
        .clk              (clk),
        .rst              (rst),
        .log_n            (log_n),
        .s_axis_tdata_max (s_axis_tdata_max),
        .s_axis_tdata_addr(s_axis_tdata_addr),
        .s_axis_tvalid    (s_axis_tvalid),
        .m_axis_tdata_max (m_axis_tdata_max),
        .m_axis_tdata_addr(m_axis_tdata_addr),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .overflow         (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic resetModel();
        m_count = 0;
        m_sum_v = '0;
        m_sum_a = '0;
    endtask

    // Drives one sample for one clock and advances the reference batch model.
    task automatic applyStimulus(input logic [31:0] v, input logic [7:0] a);
        s_axis_tdata_max  = v;
        s_axis_tdata_addr = a;
        s_axis_tvalid     = 1'b1;
        if (m_count == 0) m_n = (log_n > 4'd10) ? 10 : int'(log_n);
        m_count++;
        m_sum_v += 64'(v);
        m_sum_a += 64'(a);
        if (m_count == (1 << m_n)) begin
            sb_q.push_back('{mx: 32'(m_sum_v >> m_n), ad: 8'(m_sum_a >> m_n)});
            resetModel();
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            if (sb_q.size() == 0) begin
                checkOutput("sb_unexpected", 64'(m_axis_tdata_max), 64'hDEAD);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("sb_max", 64'(m_axis_tdata_max), 64'(e.mx));
                checkOutput("sb_addr", 64'(m_axis_tdata_addr), 64'(e.ad));
            end
        end
    end

    initial begin
        rst = 1'b1;
        log_n = 4'd0;
        s_axis_tdata_max = '0;
        s_axis_tdata_addr = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 64'(m_axis_tvalid), 0);
        checkOutput("rst_max", 64'(m_axis_tdata_max), 0);
        checkOutput("rst_addr", 64'(m_axis_tdata_addr), 0);
        checkOutput("rst_ovf", 64'(overflow), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // log_n=2 basic batch
        log_n = 4'd2;
        applyStimulus(3, 10);
        applyStimulus(5, 12);
        applyStimulus(7, 14);
        @(negedge clk);
        checkOutput("b2_early_valid", 64'(m_axis_tvalid), 0);
        applyStimulus(1, 16);
        @(negedge clk);
        checkOutput("b2_valid", 64'(m_axis_tvalid), 1);
        checkOutput("b2_max", 64'(m_axis_tdata_max), 4);
        checkOutput("b2_addr", 64'(m_axis_tdata_addr), 13);
        @(negedge clk);
        checkOutput("b2_valid_drop", 64'(m_axis_tvalid), 0);

        // n=0 pass-through, then back-to-back load during accept
        log_n = 4'd0;
        applyStimulus(42, 200);
        @(negedge clk);
        checkOutput("n0_valid", 64'(m_axis_tvalid), 1);
        checkOutput("n0_max", 64'(m_axis_tdata_max), 42);
        checkOutput("n0_addr", 64'(m_axis_tdata_addr), 200);
        applyStimulus(7, 9);
        applyStimulus(11, 13);
        @(negedge clk);
        checkOutput("b2b_valid", 64'(m_axis_tvalid), 1);
        checkOutput("b2b_max", 64'(m_axis_tdata_max), 11);
        checkOutput("b2b_ovf", 64'(overflow), 0);
        @(negedge clk);
        checkOutput("b2b_valid_drop", 64'(m_axis_tvalid), 0);

        // Backpressure: second result is dropped and flagged
        m_axis_tready = 1'b0;
        log_n = 4'd1;
        applyStimulus(2, 2);
        applyStimulus(4, 4);
        @(negedge clk);
        checkOutput("bp_first_max", 64'(m_axis_tdata_max), 3);
        applyStimulus(10, 10);
        applyStimulus(20, 20);
        @(negedge clk);
        checkOutput("bp_valid", 64'(m_axis_tvalid), 1);
        checkOutput("bp_max", 64'(m_axis_tdata_max), 3);
        checkOutput("bp_addr", 64'(m_axis_tdata_addr), 3);
        checkOutput("bp_ovf", 64'(overflow), 1);
        void'(sb_q.pop_back());
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        @(negedge clk);
        checkOutput("bp_hs_valid", 64'(m_axis_tvalid), 1);
        @(negedge clk);
        checkOutput("bp_after_valid", 64'(m_axis_tvalid), 0);
        checkOutput("bp_ovf_sticky", 64'(overflow), 1);

        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ovf_cleared", 64'(overflow), 0);

        // Full-scale 1024-sample batch, then clamped log_n=15
        log_n = 4'd10;
        for (int i = 0; i < 1023; i++) applyStimulus(32'hFFFF_FFFF, 8'd255);
        @(negedge clk);
        checkOutput("big_early_valid", 64'(m_axis_tvalid), 0);
        applyStimulus(32'hFFFF_FFFF, 8'd255);
        @(negedge clk);
        checkOutput("big_max", 64'(m_axis_tdata_max), 64'hFFFF_FFFF);
        checkOutput("big_addr", 64'(m_axis_tdata_addr), 255);
        checkOutput("big_ovf", 64'(overflow), 0);
        log_n = 4'd15;
        for (int i = 0; i < 1023; i++) applyStimulus(32'(i), 8'(i));
        @(negedge clk);
        checkOutput("clamp_early_valid", 64'(m_axis_tvalid), 0);
        applyStimulus(32'd1023, 8'd255);
        @(negedge clk);
        checkOutput("clamp_max", 64'(m_axis_tdata_max), 511);
        checkOutput("clamp_addr", 64'(m_axis_tdata_addr), 127);

        // Reset mid-batch discards partial sums and ignores tvalid
        log_n = 4'd2;
        applyStimulus(5, 5);
        applyStimulus(6, 6);
        rst = 1'b1;
        s_axis_tdata_max = 32'd99;
        s_axis_tdata_addr = 8'd99;
        s_axis_tvalid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        resetModel();
        @(negedge clk);
        checkOutput("mid_rst_valid", 64'(m_axis_tvalid), 0);
        checkOutput("mid_rst_max", 64'(m_axis_tdata_max), 0);
        checkOutput("mid_rst_addr", 64'(m_axis_tdata_addr), 0);
        for (int i = 0; i < 4; i++) applyStimulus(8, 8);
        @(negedge clk);
        checkOutput("post_rst_max", 64'(m_axis_tdata_max), 8);
        checkOutput("post_rst_addr", 64'(m_axis_tdata_addr), 8);

        // log_n change mid-batch only affects the following batch
        applyStimulus(1, 1);
        log_n = 4'd3;
        applyStimulus(1, 1);
        applyStimulus(1, 1);
        @(negedge clk);
        checkOutput("chg_early_valid", 64'(m_axis_tvalid), 0);
        applyStimulus(5, 1);
        @(negedge clk);
        checkOutput("chg_first_valid", 64'(m_axis_tvalid), 1);
        checkOutput("chg_first_max", 64'(m_axis_tdata_max), 2);
        for (int i = 1; i < 8; i++) applyStimulus(32'(i), 8'(2 * i));
        @(negedge clk);
        checkOutput("chg_second_early", 64'(m_axis_tvalid), 0);
        applyStimulus(8, 16);
        @(negedge clk);
        checkOutput("chg_second_max", 64'(m_axis_tdata_max), 4);
        checkOutput("chg_second_addr", 64'(m_axis_tdata_addr), 9);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        checkOutput("sb_drain", 64'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
